fcs_tx_stream: RTL and testbench
================================

# fcs_tx_stream

Parametrised Ethernet frame-check-sequence inserter on a valid/ready byte-lane stream. It sits between the ARP/UDP frame builders and the preamble/SFD stage. It accepts a frame from destination MAC through payload. When enabled, it zero-pads the frame to the minimum length. It appends the 4-byte CRC-32, packing pad and FCS bytes into the unused lanes of the last beat. It generalises the byte-wide FCS block to 1/2/4/8-byte datapaths with back-pressure and padding.

## Interface
- DATA_BYTES, 1, datapath width in bytes; legal values 1, 2, 4, 8.
- PAD_EN, 1, 1 = zero-pad frames shorter than MIN_FRAME bytes (pre-FCS); 0 = no padding.
- MIN_FRAME, 60, minimum pre-FCS frame length in bytes when PAD_EN=1.
- Reset is aresetn, synchronous, active-low. The clock is aclk.
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- s_tdata  in  8*DATA_BYTES  input bytes; lane 0 (bits 7:0) is first on the wire.
- s_tkeep  in  DATA_BYTES  lane valid; all-ones except on the tlast beat, where it is contiguous from lane 0 (0 allowed).
- s_tlast  in  1  last beat of frame.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat accepted when s_tvalid && s_tready.
- m_tdata  out  8*DATA_BYTES  output bytes (frame + pad + FCS).
- m_tkeep  out  DATA_BYTES  output lane valid; contiguous from lane 0.
- m_tlast  out  1  beat carrying the final FCS byte.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream accept.
- fcs_tx_done  out  1  one-cycle pulse when the m_tlast beat is accepted.

## Operation
- CRC-32:
  - reflected polynomial 0xEDB88320, init 0xFFFFFFFF, processed LSB-first per byte, lanes in ascending order;
  - FCS = ~crc, emitted byte 0 (crc[7:0]) first;
  - pad bytes (0x00) are included in the CRC.
- States:
  - DATA: pass-through; the CRC updates over kept lanes of each accepted beat.
  - TAIL: emits remaining pad and FCS bytes. s_tready=0 in TAIL.
- byte_cnt counts accepted data bytes and saturates at MIN_FRAME.
- On the accepted tlast beat with k kept lanes:
  - pad_rem = PAD_EN ? max(0, MIN_FRAME − (byte_cnt + k)) : 0;
  - tail = pad_rem pad bytes followed by FCS bytes 0..3;
  - lanes k..DATA_BYTES−1 of that output beat are filled from the tail in order.
- If the tail fits in the last beat, that beat has m_tlast=1, the state stays DATA, and the CRC and byte_cnt reinit.
- Otherwise the state goes to TAIL. Each TAIL beat fills lanes from 0 with the next tail bytes. The beat holding FCS byte 3 has m_tlast=1, keep covers through that lane, and the state returns to DATA.
- The CRC for FCS lanes includes all pad lanes preceding them, within the same beat if necessary.
- k=0 on tlast: the frame is pad + FCS only.

## Timing
- The output is a single register stage. An accepted input beat appears on m_* in the next cycle.
- s_tready = (state==DATA) && (!m_tvalid || m_tready).
- m_* hold stable while m_tvalid && !m_tready.
- The TAIL beat count is ceil(remaining tail bytes / DATA_BYTES). TAIL advances only on m_tready.
- Back-to-back frames: a new frame's first beat can be accepted in the cycle the previous m_tlast beat is accepted, provided the state is DATA.
- fcs_tx_done is asserted in the same cycle as m_tvalid && m_tready && m_tlast.
- Reset values:
  - state DATA, crc 0xFFFFFFFF, byte_cnt 0, pad_rem 0, FCS index 0;
  - m_tvalid 0, m_tlast 0, m_tdata 0, m_tkeep 0, fcs_tx_done 0;
  - s_tready is 1 from the first cycle after reset.
- Reset mid-frame discards the frame. No partial FCS is emitted.
- Frames with ≥ MIN_FRAME data bytes get no pad. Frame length is otherwise unbounded, since byte_cnt saturates.

## Structure
- Package eth_pkg holds the following shared definitions:
  - CRC32_POLY = 0xEDB88320, CRC32_INIT = 0xFFFFFFFF, CRC32_RESIDUE = 0xDEBB20E3;
  - ETH_MIN_FRAME = 60;
  - function crc32_byte(crc, byte);
  - the state enum type.
- Sub-module crc32_lanes is combinational. It takes the current crc, DATA_BYTES lanes and a per-lane enable, and returns the crc after each lane, so FCS lanes can select the value preceding them.
- fcs_tx_stream holds the FSM, counters, lane-source mux and output register.

## Test plan
- DATA_BYTES=1, PAD_EN=0, frame ASCII "123456789" → output the 9 bytes, then 0x26 0x39 0xF4 0xCB with m_tlast on 0xCB and one fcs_tx_done pulse.
- DATA_BYTES=4, PAD_EN=0, same frame (last beat keep 0001) → last beat is {39,26,F4?..} lanes: 0x39(data '9'),0x26,0x39,0xF4 keep 1111, then beat 0xCB keep 0001 tlast.
- DATA_BYTES=8, PAD_EN=1, 14-byte frame → 46 zero pad bytes then FCS; total 64 bytes in 8 beats, last keep 0xFF. Recomputing the CRC over all 64 bytes, without the final invert, gives 0xDEBB20E3.
- DATA_BYTES=2, k=0 tlast on the first beat, PAD_EN=1 → 60 zeros + FCS; the residue check passes.
- Random m_tready back-pressure across 200 random frames of 1–1518 bytes, all widths → data is unchanged, the residue holds per frame, and m_* are stable while stalled.
- aresetn asserted during TAIL → next cycle m_tvalid=0; the next frame's FCS is correct, with no state carried over.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: CRC-32 constants, minimum frame length, the
// reflected CRC-32 byte step and the FCS inserter state type.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          ETH_MIN_FRAME = 60;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_TAIL = 1'b1
  } fcs_state_e;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_lanes.sv
// Combinational multi-lane CRC-32 step. o_crc[i] is the CRC seen before lane i,
// o_crc[DATA_BYTES] the CRC after the whole beat; disabled lanes pass through.
module crc32_lanes
  import eth_pkg::*;
#(
  parameter int DATA_BYTES = 1
) (
  input  logic [31:0]                i_crc,
  input  logic [DATA_BYTES-1:0][7:0] i_data,
  input  logic [DATA_BYTES-1:0]      i_en,
  output logic [DATA_BYTES:0][31:0]  o_crc
);

  logic [31:0] w_c;

  always_comb begin
    w_c      = i_crc;
    o_crc    = '0;
    o_crc[0] = w_c;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (i_en[i]) w_c = crc32_byte(w_c, i_data[i]);
      o_crc[i+1] = w_c;
    end
  end

endmodule

// File: rtl/fcs_tx_stream.sv
// Ethernet FCS inserter on a 1/2/4/8-byte valid/ready stream: optional zero
// padding to the minimum length, CRC-32 append packed into the spare lanes.
module fcs_tx_stream
  import eth_pkg::*;
#(
  parameter int DATA_BYTES = 1,
  parameter int PAD_EN     = 1,
  parameter int MIN_FRAME  = ETH_MIN_FRAME
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [8*DATA_BYTES-1:0] s_tdata,
  input  logic [DATA_BYTES-1:0]   s_tkeep,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [8*DATA_BYTES-1:0] m_tdata,
  output logic [DATA_BYTES-1:0]   m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    fcs_tx_done
);

  localparam int CW = 16;

  fcs_state_e              r_state, w_state_nxt;
  logic [31:0]             r_crc;
  logic [CW-1:0]           r_byte_cnt;
  logic [CW-1:0]           r_pad_rem;
  logic [2:0]              r_fcs_idx;

  logic [8*DATA_BYTES-1:0] r_tdata_p1;
  logic [DATA_BYTES-1:0]   r_tkeep_p1;
  logic                    r_tlast_p1;
  logic                    r_vld_p1;

  logic                    w_s_ready, w_accept, w_tail_adv, w_load;
  logic [CW-1:0]           w_kcnt, w_k, w_sum, w_pad0, w_t, w_f, w_pad_used;
  logic [2:0]              w_fidx0, w_fcs_used;
  logic                    w_tail_on, w_last;
  logic [DATA_BYTES-1:0]   w_en, w_keep, w_is_fcs;
  logic [DATA_BYTES-1:0][7:0] w_lane_d;
  logic [DATA_BYTES-1:0][1:0] w_fsel;
  logic [DATA_BYTES:0][31:0]  w_crc;
  logic [8*DATA_BYTES-1:0] w_tdata;
  logic [31:0]             w_fcs;

  function automatic logic [CW-1:0] sat_cnt(input logic [CW-1:0] v);
    return (v >= CW'(MIN_FRAME)) ? CW'(MIN_FRAME) : v;
  endfunction

  assign w_s_ready  = (r_state == ST_DATA) && (!r_vld_p1 || m_tready);
  assign w_accept   = s_tvalid && w_s_ready;
  assign w_tail_adv = (r_state == ST_TAIL) && (!r_vld_p1 || m_tready);
  assign w_load     = w_accept || w_tail_adv;

  // Lane classification: data lanes first, then pad bytes, then FCS bytes.
  always_comb begin
    w_kcnt     = '0;
    w_k        = '0;
    w_sum      = '0;
    w_pad0     = '0;
    w_fidx0    = '0;
    w_tail_on  = 1'b0;
    w_t        = '0;
    w_f        = '0;
    w_pad_used = '0;
    w_fcs_used = '0;
    w_last     = 1'b0;
    w_en       = '0;
    w_keep     = '0;
    w_is_fcs   = '0;
    w_lane_d   = '0;
    w_fsel     = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (s_tkeep[i]) w_kcnt = w_kcnt + CW'(1);
    end
    if (r_state == ST_DATA) begin
      w_k       = w_kcnt;
      w_sum     = r_byte_cnt + w_k;
      w_tail_on = s_tlast;
      if ((PAD_EN != 0) && s_tlast && (w_sum < CW'(MIN_FRAME))) w_pad0 = CW'(MIN_FRAME) - w_sum;
    end else begin
      w_sum     = r_byte_cnt;
      w_tail_on = 1'b1;
      w_pad0    = r_pad_rem;
      w_fidx0   = r_fcs_idx;
    end
    for (int i = 0; i < DATA_BYTES; i++) begin
      w_t = CW'(i) - w_k;
      if (CW'(i) < w_k) begin
        w_en[i]     = 1'b1;
        w_keep[i]   = 1'b1;
        w_lane_d[i] = s_tdata[8*i +: 8];
      end else if (w_tail_on) begin
        if (w_t < w_pad0) begin
          w_en[i]    = 1'b1;
          w_keep[i]  = 1'b1;
          w_pad_used = w_pad_used + CW'(1);
        end else begin
          w_f = CW'(w_fidx0) + w_t - w_pad0;
          if (w_f < CW'(4)) begin
            w_keep[i]   = 1'b1;
            w_is_fcs[i] = 1'b1;
            w_fsel[i]   = w_f[1:0];
            w_fcs_used  = w_fcs_used + 3'd1;
            if (w_f == CW'(3)) w_last = 1'b1;
          end
        end
      end
    end
  end

  crc32_lanes #(
    .DATA_BYTES (DATA_BYTES)
  ) u_crc (
    .i_crc  (r_crc),
    .i_data (w_lane_d),
    .i_en   (w_en),
    .o_crc  (w_crc)
  );

  // FCS lanes take the inverted CRC as it stood just before them.
  always_comb begin
    w_tdata = '0;
    w_fcs   = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      w_fcs = ~w_crc[i];
      if (w_is_fcs[i])  w_tdata[8*i +: 8] = w_fcs[8*w_fsel[i] +: 8];
      else if (w_en[i]) w_tdata[8*i +: 8] = w_lane_d[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_DATA: if (w_accept && s_tlast && !w_last) w_state_nxt = ST_TAIL;
      ST_TAIL: if (w_tail_adv && w_last)           w_state_nxt = ST_DATA;
      default:                                     w_state_nxt = ST_DATA;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state    <= ST_DATA;
      r_crc      <= CRC32_INIT;
      r_byte_cnt <= '0;
      r_pad_rem  <= '0;
      r_fcs_idx  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        if (w_last) begin
          r_crc      <= CRC32_INIT;
          r_byte_cnt <= '0;
          r_pad_rem  <= '0;
          r_fcs_idx  <= '0;
        end else begin
          r_crc      <= w_crc[DATA_BYTES];
          r_byte_cnt <= sat_cnt(w_sum);
          r_pad_rem  <= w_pad0 - w_pad_used;
          r_fcs_idx  <= w_fidx0 + w_fcs_used;
        end
      end
    end
  end

  // Output register stage (p1): holds while stalled.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_vld_p1   <= 1'b0;
      r_tlast_p1 <= 1'b0;
      r_tdata_p1 <= '0;
      r_tkeep_p1 <= '0;
    end else if (w_load) begin
      r_vld_p1   <= 1'b1;
      r_tlast_p1 <= w_last;
      r_tdata_p1 <= w_tdata;
      r_tkeep_p1 <= w_keep;
    end else if (m_tready) begin
      r_vld_p1   <= 1'b0;
      r_tlast_p1 <= 1'b0;
    end
  end

  assign s_tready    = w_s_ready;
  assign m_tdata     = r_tdata_p1;
  assign m_tkeep     = r_tkeep_p1;
  assign m_tlast     = r_tlast_p1;
  assign m_tvalid    = r_vld_p1;
  assign fcs_tx_done = r_vld_p1 && m_tready && r_tlast_p1;

endmodule

// File: tb/tb_fcs_tx_stream.sv
// Bench for fcs_tx_stream: four instances (1B/nopad, 2B/pad, 4B/nopad, 8B/pad),
// directed frames, random frames with back-pressure, reset during the tail.
module tb_fcs_tx_stream;

  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam int          MINF    = 60;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [7:0]  sd0, md0;
  logic [0:0]  sk0, mk0;
  logic [15:0] sd1, md1;
  logic [1:0]  sk1, mk1;
  logic [31:0] sd2, md2;
  logic [3:0]  sk2, mk2;
  logic [63:0] sd3, md3;
  logic [7:0]  sk3, mk3;
  logic s_tlast[4], s_tvalid[4], s_tready[4];
  logic m_tlast[4], m_tvalid[4], m_tready[4], tx_done[4];

  fcs_tx_stream #(.DATA_BYTES(1), .PAD_EN(0), .MIN_FRAME(MINF)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .s_tdata(sd0), .s_tkeep(sk0), .s_tlast(s_tlast[0]),
    .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]), .m_tdata(md0), .m_tkeep(mk0),
    .m_tlast(m_tlast[0]), .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .fcs_tx_done(tx_done[0]));
  fcs_tx_stream #(.DATA_BYTES(2), .PAD_EN(1), .MIN_FRAME(MINF)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .s_tdata(sd1), .s_tkeep(sk1), .s_tlast(s_tlast[1]),
    .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]), .m_tdata(md1), .m_tkeep(mk1),
    .m_tlast(m_tlast[1]), .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .fcs_tx_done(tx_done[1]));
  fcs_tx_stream #(.DATA_BYTES(4), .PAD_EN(0), .MIN_FRAME(MINF)) u_dut2 (
    .aclk(aclk), .aresetn(aresetn), .s_tdata(sd2), .s_tkeep(sk2), .s_tlast(s_tlast[2]),
    .s_tvalid(s_tvalid[2]), .s_tready(s_tready[2]), .m_tdata(md2), .m_tkeep(mk2),
    .m_tlast(m_tlast[2]), .m_tvalid(m_tvalid[2]), .m_tready(m_tready[2]), .fcs_tx_done(tx_done[2]));
  fcs_tx_stream #(.DATA_BYTES(8), .PAD_EN(1), .MIN_FRAME(MINF)) u_dut3 (
    .aclk(aclk), .aresetn(aresetn), .s_tdata(sd3), .s_tkeep(sk3), .s_tlast(s_tlast[3]),
    .s_tvalid(s_tvalid[3]), .s_tready(s_tready[3]), .m_tdata(md3), .m_tkeep(mk3),
    .m_tlast(m_tlast[3]), .m_tvalid(m_tvalid[3]), .m_tready(m_tready[3]), .fcs_tx_done(tx_done[3]));

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned rx_q[$];
  int           mon_beats, mon_stall_bad, mon_done, mon_done_bad, mon_keep_bad;
  logic [7:0]   mon_last_keep;
  bit           mon_to, drv_to;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dbw(input int g);
    return 1 << g;
  endfunction

  task automatic set_in(input int g, input logic [63:0] d, input logic [7:0] k);
    case (g)
      0: begin sd0 = d[7:0];  sk0 = k[0:0]; end
      1: begin sd1 = d[15:0]; sk1 = k[1:0]; end
      2: begin sd2 = d[31:0]; sk2 = k[3:0]; end
      default: begin sd3 = d; sk3 = k; end
    endcase
  endtask

  function automatic logic [63:0] get_md(input int g);
    case (g)
      0: return 64'(md0);
      1: return 64'(md1);
      2: return 64'(md2);
      default: return md3;
    endcase
  endfunction

  function automatic logic [7:0] get_mk(input int g);
    case (g)
      0: return 8'(mk0);
      1: return 8'(mk1);
      2: return 8'(mk2);
      default: return mk3;
    endcase
  endfunction

  // CRC register after a byte sequence, without the final inversion.
  function automatic logic [31:0] crc_raw(input byte unsigned q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build_exp(input int g, input byte unsigned d[$], output byte unsigned e[$]);
    logic [31:0] f;
    e = d;
    if (g % 2 == 1) while (e.size() < MINF) e.push_back(8'h00);
    f = ~crc_raw(e);
    for (int i = 0; i < 4; i++) e.push_back(f[8*i +: 8]);
  endtask

  task automatic drive(input int g, input byte unsigned d[$], input bit zero_last, input int gap_pct);
    int n, db, nbeats, cyc, pos;
    logic [63:0] dd;
    logic [7:0] kk;
    bit acc;
    n  = d.size();
    db = dbw(g);
    nbeats = zero_last ? (n / db + 1) : ((n + db - 1) / db);
    drv_to = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      dd = '0;
      kk = '0;
      for (int l = 0; l < db; l++) begin
        pos = b * db + l;
        if (pos < n) begin
          dd[8*l +: 8] = d[pos];
          kk[l] = 1'b1;
        end
      end
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        @(negedge aclk);
        s_tvalid[g] = 1'b0;
      end
      @(negedge aclk);
      set_in(g, dd, kk);
      s_tlast[g]  = (b == nbeats - 1);
      s_tvalid[g] = 1'b1;
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 5000) begin
        #1;
        acc = s_tready[g];
        if (!acc) begin
          @(negedge aclk);
          cyc++;
        end
      end
      if (!acc) begin
        drv_to = 1'b1;
        s_tvalid[g] = 1'b0;
        return;
      end
      @(posedge aclk);
    end
    #1;
    s_tvalid[g] = 1'b0;
    s_tlast[g]  = 1'b0;
  endtask

  task automatic monitor(input int g, input int rdy_pct);
    logic [63:0] d, hd;
    logic [7:0]  k, hk;
    logic [8:0]  kx;
    logic        v, l, r, hl, held, fin;
    int          cyc;
    rx_q.delete();
    mon_beats = 0; mon_stall_bad = 0; mon_done = 0; mon_done_bad = 0; mon_keep_bad = 0;
    mon_last_keep = '0;
    mon_to = 1'b0;
    held = 1'b0;
    fin  = 1'b0;
    hd = '0; hk = '0; hl = 1'b0;
    cyc = 0;
    while (!fin && cyc < 20000) begin
      @(negedge aclk);
      m_tready[g] = ($urandom_range(0, 99) < rdy_pct);
      #2;
      v = m_tvalid[g];
      r = m_tready[g];
      d = get_md(g);
      k = get_mk(g);
      l = m_tlast[g];
      if (held && (!v || d != hd || k != hk || l != hl)) mon_stall_bad++;
      if (tx_done[g]) mon_done++;
      if (tx_done[g] != (v && r && l)) mon_done_bad++;
      if (v && r) begin
        kx = {1'b0, k};
        if (k == '0 || (kx & (kx + 9'd1)) != '0) mon_keep_bad++;
        for (int i = 0; i < dbw(g); i++) if (k[i]) rx_q.push_back(d[8*i +: 8]);
        mon_beats++;
        if (l) begin
          fin = 1'b1;
          mon_last_keep = k;
        end
        held = 1'b0;
      end else if (v) begin
        held = 1'b1;
        hd = d; hk = k; hl = l;
      end else begin
        held = 1'b0;
      end
      cyc++;
    end
    if (!fin) mon_to = 1'b1;
  endtask

  task automatic run_frame(input int g, input byte unsigned d[$], input bit zero_last,
                           input int gap, input int rdy, input string tag);
    byte unsigned e[$];
    int db, rem, nbad;
    logic [7:0] ekeep;
    build_exp(g, d, e);
    fork
      drive(g, d, zero_last, gap);
      monitor(g, rdy);
    join
    db  = dbw(g);
    rem = e.size() % db;
    ekeep = (rem == 0) ? 8'((1 << db) - 1) : 8'((1 << rem) - 1);
    nbad = 0;
    for (int i = 0; i < e.size() && i < rx_q.size(); i++) if (rx_q[i] != e[i]) nbad++;
    chk({tag, " timeout"}, 64'(mon_to || drv_to), 64'(0));
    chk({tag, " len"}, rx_q.size(), e.size());
    chk({tag, " data"}, nbad, 0);
    chk({tag, " residue"}, crc_raw(rx_q), RESIDUE);
    chk({tag, " beats"}, mon_beats, (e.size() + db - 1) / db);
    chk({tag, " last_keep"}, mon_last_keep, ekeep);
    chk({tag, " stall"}, mon_stall_bad, 0);
    chk({tag, " keep_contig"}, mon_keep_bad, 0);
    chk({tag, " done_cnt"}, mon_done, 1);
    chk({tag, " done_align"}, mon_done_bad, 0);
  endtask

  function automatic logic [7:0] rxb(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'h00;
  endfunction

  initial begin
    byte unsigned d[$];
    byte unsigned empty_q[$];
    string s;
    int g, len, db, gap, rdy;
    bit zl;

    for (int i = 0; i < 4; i++) begin
      s_tvalid[i] = 1'b0;
      s_tlast[i]  = 1'b0;
      m_tready[i] = 1'b1;
      set_in(i, '0, '0);
    end
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    for (int i = 0; i < 4; i++) begin
      chk("rst m_tvalid", 64'(m_tvalid[i]), 64'(0));
      chk("rst m_tlast", 64'(m_tlast[i]), 64'(0));
      chk("rst m_tdata", get_md(i), 64'(0));
      chk("rst m_tkeep", 64'(get_mk(i)), 64'(0));
      chk("rst done", 64'(tx_done[i]), 64'(0));
    end
    aresetn = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 4; i++) chk("rst s_tready", 64'(s_tready[i]), 64'(1));

    s = "123456789";
    for (int i = 0; i < s.len(); i++) d.push_back(s[i]);

    run_frame(0, d, 1'b0, 0, 100, "t1");
    chk("t1 fcs0", rxb(9),  8'h26);
    chk("t1 fcs1", rxb(10), 8'h39);
    chk("t1 fcs2", rxb(11), 8'hF4);
    chk("t1 fcs3", rxb(12), 8'hCB);

    run_frame(2, d, 1'b0, 0, 100, "t2");
    chk("t2 lane0", rxb(8),  8'h39);
    chk("t2 fcs0",  rxb(9),  8'h26);
    chk("t2 fcs3",  rxb(12), 8'hCB);

    d.delete();
    for (int i = 0; i < 14; i++) d.push_back(8'($urandom));
    run_frame(3, d, 1'b0, 0, 100, "t3");
    chk("t3 len64", rx_q.size(), 64);
    chk("t3 beats8", mon_beats, 8);
    chk("t3 pad", {rxb(14), rxb(37), rxb(59)}, 24'h0);

    run_frame(1, empty_q, 1'b1, 0, 100, "t4");
    chk("t4 len64", rx_q.size(), 64);

    d.delete();
    for (int i = 0; i < 60; i++) d.push_back(8'($urandom));
    run_frame(3, d, 1'b0, 10, 60, "min60");
    d.pop_back();
    run_frame(1, d, 1'b0, 10, 60, "min59");

    // Reset while the 1-byte instance is emitting its FCS tail.
    d.delete();
    for (int i = 0; i < 3; i++) d.push_back(8'($urandom));
    m_tready[0] = 1'b1;
    drive(0, d, 1'b0, 0);
    @(negedge aclk);
    @(negedge aclk);
    #1;
    chk("tail s_tready", 64'(s_tready[0]), 64'(0));
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    chk("midrst m_tvalid", 64'(m_tvalid[0]), 64'(0));
    chk("midrst m_tlast", 64'(m_tlast[0]), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    d.delete();
    for (int i = 0; i < s.len(); i++) d.push_back(s[i]);
    run_frame(0, d, 1'b0, 0, 100, "after_rst");
    chk("after_rst fcs0", rxb(9),  8'h26);
    chk("after_rst fcs3", rxb(12), 8'hCB);

    for (int f = 0; f < 200; f++) begin
      g   = $urandom_range(0, 3);
      db  = dbw(g);
      len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 80) : $urandom_range(1, 1518);
      zl  = (len % db == 0) && ($urandom_range(0, 3) == 0);
      gap = $urandom_range(0, 30);
      rdy = $urandom_range(40, 100);
      d.delete();
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      run_frame(g, d, zl, gap, rdy, $sformatf("rnd%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
